// File: rtl/sprite_layer.sv
// sprite_layer: composites N_SPRITES independently positioned sprites onto
// the VGA raster. Each slot has a shadow register set written by game logic
// and an active set that only changes on frame_start, so a frame never
// renders a half-updated sprite layout. Three-stage pipeline:
//   S1 hit test + sheet address, S2 sheet read, S3 priority + palette read.
// Sheet and palette ROM contents are provided by the surrounding environment.

module sprite_layer #(
   parameter int    N_SPRITES    = 4,
   parameter int    SPR_W        = 32,
   parameter int    SPR_H        = 32,
   parameter int    PIX_W        = 4,
   parameter int    COLR_W       = 12,
   parameter string SHEET_FILE   = "doodle.mem",
   parameter string PALETTE_FILE = "doodle_palette.mem"
) (
   input  logic              i_clk_25,
   input  logic              i_rst,
   input  logic [15:0]       i_sx,
   input  logic [15:0]       i_sy,
   input  logic              i_de,
   input  logic              i_frame_start,
   input  logic              i_cfg_we,
   input  logic [2:0]        i_cfg_id,
   input  logic [15:0]       i_cfg_x,
   input  logic [15:0]       i_cfg_y,
   input  logic              i_cfg_en,
   input  logic              i_cfg_scale,
   output logic              o_valid,
   output logic              o_hit,
   output logic [2:0]        o_hit_id,
   output logic [PIX_W-1:0]  o_pix,
   output logic [COLR_W-1:0] o_colr
);

   localparam int SPR_SIZE    = SPR_W * SPR_H;
   localparam int SHEET_DEPTH = N_SPRITES * SPR_SIZE;
   localparam int ADDR_W      = $clog2(SHEET_DEPTH);
   localparam int DX_W        = $clog2(SPR_W);
   localparam int DY_W        = $clog2(SPR_H);
   localparam int PAL_DEPTH   = 1 << PIX_W;

   // Shared sprite sheet (sprite k at base k*SPR_SIZE, row-major) and palette
   logic [PIX_W-1:0]  sheet_mem   [SHEET_DEPTH];
   logic [COLR_W-1:0] palette_mem [PAL_DEPTH];

   logic             de_s1;
   logic             de_s2;
   logic [PIX_W-1:0] slot_pix [N_SPRITES];

   for (genvar k = 0; k < N_SPRITES; k++) begin : g_slot
      logic [15:0]       shadow_x;
      logic [15:0]       shadow_y;
      logic              shadow_en;
      logic              shadow_scale;
      logic [15:0]       active_x;
      logic [15:0]       active_y;
      logic              active_en;
      logic              active_scale;
      logic              cfg_sel;
      logic [16:0]       sx_ext;
      logic [16:0]       sy_ext;
      logic [16:0]       x_lo;
      logic [16:0]       y_lo;
      logic [16:0]       x_hi;
      logic [16:0]       y_hi;
      logic [DX_W:0]     off_x;
      logic [DY_W:0]     off_y;
      logic [DX_W-1:0]   dx;
      logic [DY_W-1:0]   dy;
      logic              hit_c;
      logic [ADDR_W-1:0] addr_c;
      logic              hit_s1;
      logic [ADDR_W-1:0] addr_s1;
      logic [PIX_W-1:0]  pix_s2;

      // Ids outside 0..N_SPRITES-1 never match any slot, so they are dropped
      assign cfg_sel = i_cfg_we && (i_cfg_id == 3'(k));

      // Shadow registers take every config write immediately
      always_ff @(posedge i_clk_25 or posedge i_rst) begin
         if (i_rst) begin
            shadow_x     <= '0;
            shadow_y     <= '0;
            shadow_en    <= 1'b0;
            shadow_scale <= 1'b0;
         end else if (cfg_sel) begin
            shadow_x     <= i_cfg_x;
            shadow_y     <= i_cfg_y;
            shadow_en    <= i_cfg_en;
            shadow_scale <= i_cfg_scale;
         end
      end

      // Active registers copy shadow on frame_start; a same-cycle write goes straight through
      always_ff @(posedge i_clk_25 or posedge i_rst) begin
         if (i_rst) begin
            active_x     <= '0;
            active_y     <= '0;
            active_en    <= 1'b0;
            active_scale <= 1'b0;
         end else if (i_frame_start) begin
            active_x     <= cfg_sel ? i_cfg_x     : shadow_x;
            active_y     <= cfg_sel ? i_cfg_y     : shadow_y;
            active_en    <= cfg_sel ? i_cfg_en    : shadow_en;
            active_scale <= cfg_sel ? i_cfg_scale : shadow_scale;
         end
      end

      // Hit test in 17 bits so a sprite near 0xFFFF cannot wrap onto column/row 0
      always_comb begin
         sx_ext = {1'b0, i_sx};
         sy_ext = {1'b0, i_sy};
         x_lo   = {1'b0, active_x};
         y_lo   = {1'b0, active_y};
         x_hi   = x_lo + (17'(SPR_W) << active_scale);
         y_hi   = y_lo + (17'(SPR_H) << active_scale);
         off_x  = (DX_W+1)'(i_sx - active_x);
         off_y  = (DY_W+1)'(i_sy - active_y);
         dx     = active_scale ? off_x[DX_W:1] : off_x[DX_W-1:0];
         dy     = active_scale ? off_y[DY_W:1] : off_y[DY_W-1:0];
         hit_c  = active_en &&
                  (sx_ext >= x_lo) && (sx_ext < x_hi) &&
                  (sy_ext >= y_lo) && (sy_ext < y_hi);
         addr_c = ADDR_W'(k * SPR_SIZE) + ADDR_W'({dy, dx});
      end

      // S1: capture the hit flag and sheet address
      always_ff @(posedge i_clk_25 or posedge i_rst) begin
         if (i_rst) begin
            hit_s1  <= 1'b0;
            addr_s1 <= '0;
         end else begin
            hit_s1  <= hit_c;
            addr_s1 <= addr_c;
         end
      end

      // S2: synchronous sheet read; a slot that missed contributes a transparent index
      always_ff @(posedge i_clk_25 or posedge i_rst) begin
         if (i_rst) begin
            pix_s2 <= '0;
         end else begin
            pix_s2 <= hit_s1 ? sheet_mem[addr_s1] : '0;
         end
      end

      assign slot_pix[k] = pix_s2;
   end

   // Pixel-valid travels alongside the data through S1 and S2
   always_ff @(posedge i_clk_25 or posedge i_rst) begin
      if (i_rst) begin
         de_s1 <= 1'b0;
         de_s2 <= 1'b0;
      end else begin
         de_s1 <= i_de;
         de_s2 <= de_s1;
      end
   end

   logic [PIX_W-1:0] win_pix;
   logic [2:0]       win_id;

   // Priority select: scanning downward lets the lowest opaque slot win
   always_comb begin
      win_pix = '0;
      win_id  = '0;
      for (int j = N_SPRITES - 1; j >= 0; j--) begin
         if (slot_pix[j] != '0) begin
            win_pix = slot_pix[j];
            win_id  = 3'(j);
         end
      end
   end

   // S3: register the winner and its palette colour
   always_ff @(posedge i_clk_25 or posedge i_rst) begin
      if (i_rst) begin
         o_valid  <= 1'b0;
         o_hit    <= 1'b0;
         o_hit_id <= '0;
         o_pix    <= '0;
         o_colr   <= '0;
      end else begin
         o_valid  <= de_s2;
         o_hit    <= (win_pix != '0);
         o_hit_id <= win_id;
         o_pix    <= win_pix;
         o_colr   <= palette_mem[win_pix];
      end
   end

endmodule

// File: tb/tb_sprite_layer.sv
// tb_sprite_layer: directed vectors for sprite_layer. The stimulus side pushes
// the expected result of every valid pixel into a scoreboard queue; a monitor
// pops and compares whenever o_valid is seen, and also checks the 3-cycle
// valid delay every cycle. Sheet and palette are preloaded by the bench.

module tb_sprite_layer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_sx = '0;
  logic [15:0] i_sy = '0;
  logic        i_de = 1'b0;
  logic        i_frame_start = 1'b0;
  logic        i_cfg_we = 1'b0;
  logic [2:0]  i_cfg_id = '0;
  logic [15:0] i_cfg_x = '0;
  logic [15:0] i_cfg_y = '0;
  logic        i_cfg_en = 1'b0;
  logic        i_cfg_scale = 1'b0;
  logic        o_valid;
  logic        o_hit;
  logic [2:0]  o_hit_id;
  logic [3:0]  o_pix;
  logic [11:0] o_colr;

  typedef struct packed {
    logic        hit;
    logic [2:0]  id;
    logic [3:0]  pix;
    logic [11:0] colr;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] de_hist;

  always #5 clk = ~clk;

  sprite_layer #(
    .N_SPRITES(4), .SPR_W(32), .SPR_H(32), .PIX_W(4), .COLR_W(12),
    .SHEET_FILE(""), .PALETTE_FILE("")
  ) dut (
    .i_clk_25(clk), .i_rst(rst), .i_sx(i_sx), .i_sy(i_sy), .i_de(i_de),
    .i_frame_start(i_frame_start), .i_cfg_we(i_cfg_we), .i_cfg_id(i_cfg_id),
    .i_cfg_x(i_cfg_x), .i_cfg_y(i_cfg_y), .i_cfg_en(i_cfg_en),
    .i_cfg_scale(i_cfg_scale), .o_valid(o_valid), .o_hit(o_hit),
    .o_hit_id(o_hit_id), .o_pix(o_pix), .o_colr(o_colr)
  );

  // Bench palette content: colour of index i is {i, i, ~i}
  function automatic logic [11:0] pal_val(input logic [3:0] i);
    return {i, i, ~i};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One pixel per call; expected result is queued only when the pixel is valid
  task automatic applyStimulus(input logic [15:0] sx, input logic [15:0] sy, input logic de,
                               input logic hit, input logic [2:0] id, input logic [3:0] pix);
    @(negedge clk);
    i_cfg_we = 1'b0; i_frame_start = 1'b0;
    i_sx = sx; i_sy = sy; i_de = de;
    if (de) sb_q.push_back('{hit: hit, id: id, pix: pix, colr: pal_val(pix)});
  endtask

  task automatic cfgWrite(input logic [2:0] id, input logic [15:0] x, input logic [15:0] y,
                          input logic en, input logic scale, input logic fs);
    @(negedge clk);
    i_de = 1'b0; i_cfg_we = 1'b1; i_frame_start = fs;
    i_cfg_id = id; i_cfg_x = x; i_cfg_y = y; i_cfg_en = en; i_cfg_scale = scale;
  endtask

  // Frame swap while a pixel is sampled in the same cycle (must see old config)
  task automatic swapWithPixel(input logic [15:0] sx, input logic [15:0] sy,
                               input logic hit, input logic [2:0] id, input logic [3:0] pix);
    @(negedge clk);
    i_cfg_we = 1'b0; i_frame_start = 1'b1;
    i_sx = sx; i_sy = sy; i_de = 1'b1;
    sb_q.push_back('{hit: hit, id: id, pix: pix, colr: pal_val(pix)});
  endtask

  task automatic idle();
    @(negedge clk);
    i_cfg_we = 1'b0; i_frame_start = 1'b0; i_de = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(o_valid), 0);
    checkOutput({tag, "_hit"}, 32'(o_hit), 0);
    checkOutput({tag, "_id"}, 32'(o_hit_id), 0);
    checkOutput({tag, "_pix"}, 32'(o_pix), 0);
    checkOutput({tag, "_colr"}, 32'(o_colr), 0);
  endtask

  // Monitor: valid delay every cycle, scoreboard pop on each valid output
  always begin
    exp_t e;
    @(posedge clk);
    if (rst) begin
      de_hist = '0;
    end else begin
      de_hist = {de_hist[1:0], i_de};
      #1;
      checkOutput("valid_delay", 32'(o_valid), 32'(de_hist[2]));
      if (o_valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_underflow", 32'(sb_q.size()), 1);
        end else begin
          e = sb_q.pop_front();
          checkOutput("hit", 32'(o_hit), 32'(e.hit));
          checkOutput("hit_id", 32'(o_hit_id), 32'(e.id));
          checkOutput("pix", 32'(o_pix), 32'(e.pix));
          checkOutput("colr", 32'(o_colr), 32'(e.colr));
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) dut.sheet_mem[i] = 4'h0;
    for (int i = 0; i < 16; i++) dut.palette_mem[i] = pal_val(4'(i));
    dut.sheet_mem[0]    = 4'h7;
    dut.sheet_mem[1023] = 4'h2;
    dut.sheet_mem[2047] = 4'h9;
    dut.sheet_mem[2048] = 4'h3;
    dut.sheet_mem[2049] = 4'h5;
    dut.sheet_mem[3072] = 4'h4;
    dut.sheet_mem[3087] = 4'h6;
    for (int i = 3088; i < 3104; i++) dut.sheet_mem[i] = 4'h8;

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // Unconfigured sweep: nothing enabled, valid pattern follows de
    for (int i = 0; i < 12; i++)
      applyStimulus(16'(i * 37), 16'(i * 11), (i % 3) != 0, 1'b0, 3'd0, 4'h0);
    applyStimulus(16'd100, 16'd50, 1'b1, 1'b0, 3'd0, 4'h0);

    // Slot 0 at (100,50) 1x
    cfgWrite(3'd0, 16'd100, 16'd50, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'd100, 16'd50, 1'b1, 1'b1, 3'd0, 4'h7);
    applyStimulus(16'd132, 16'd50, 1'b1, 1'b0, 3'd0, 4'h0);
    applyStimulus(16'd131, 16'd81, 1'b1, 1'b1, 3'd0, 4'h2);
    applyStimulus(16'd100, 16'd82, 1'b1, 1'b0, 3'd0, 4'h0);
    applyStimulus(16'd99,  16'd50, 1'b1, 1'b0, 3'd0, 4'h0);
    applyStimulus(16'd131, 16'd50, 1'b1, 1'b0, 3'd0, 4'h0);
    applyStimulus(16'd100, 16'd50, 1'b0, 1'b0, 3'd0, 4'h0);

    // Slot 1 at (100,50) 2x: far corner reads address 2047
    cfgWrite(3'd1, 16'd100, 16'd50, 1'b1, 1'b1, 1'b1);
    applyStimulus(16'd163, 16'd113, 1'b1, 1'b1, 3'd1, 4'h9);
    applyStimulus(16'd164, 16'd113, 1'b1, 1'b0, 3'd0, 4'h0);
    applyStimulus(16'd163, 16'd114, 1'b1, 1'b0, 3'd0, 4'h0);
    applyStimulus(16'd100, 16'd50,  1'b1, 1'b1, 3'd0, 4'h7);
    applyStimulus(16'd131, 16'd81,  1'b1, 1'b1, 3'd0, 4'h2);

    // Shadow write without swap must not affect rendering
    cfgWrite(3'd0, 16'd300, 16'd50, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'd100, 16'd50, 1'b1, 1'b1, 3'd0, 4'h7);
    swapWithPixel(16'd100, 16'd50, 1'b1, 3'd0, 4'h7);
    applyStimulus(16'd100, 16'd50, 1'b1, 1'b0, 3'd0, 4'h0);
    applyStimulus(16'd300, 16'd50, 1'b1, 1'b1, 3'd0, 4'h7);

    // Write-through when write and swap coincide
    cfgWrite(3'd0, 16'd400, 16'd50, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'd400, 16'd50, 1'b1, 1'b1, 3'd0, 4'h7);
    applyStimulus(16'd300, 16'd50, 1'b1, 1'b0, 3'd0, 4'h0);

    // Slots 0 and 2 overlap at (200,200)
    cfgWrite(3'd0, 16'd200, 16'd200, 1'b1, 1'b0, 1'b0);
    cfgWrite(3'd2, 16'd200, 16'd200, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'd201, 16'd200, 1'b1, 1'b1, 3'd2, 4'h5);
    applyStimulus(16'd200, 16'd200, 1'b1, 1'b1, 3'd0, 4'h7);
    applyStimulus(16'd202, 16'd200, 1'b1, 1'b0, 3'd0, 4'h0);
    applyStimulus(16'd231, 16'd231, 1'b1, 1'b1, 3'd0, 4'h2);

    // Slot 3 near 0xFFFF must not wrap; id 5 is out of range and dropped
    cfgWrite(3'd3, 16'hFFF0, 16'd0, 1'b1, 1'b0, 1'b0);
    cfgWrite(3'd5, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'hFFF0, 16'd0, 1'b1, 1'b1, 3'd3, 4'h4);
    applyStimulus(16'hFFFF, 16'd0, 1'b1, 1'b1, 3'd3, 4'h6);
    for (int i = 0; i < 16; i++)
      applyStimulus(16'(i), 16'd0, 1'b1, 1'b0, 3'd0, 4'h0);
    applyStimulus(16'd31,  16'd31,  1'b1, 1'b0, 3'd0, 4'h0);
    applyStimulus(16'd163, 16'd113, 1'b1, 1'b1, 3'd1, 4'h9);

    // Mid-frame reset: outputs clear asynchronously, sprites disabled afterwards
    repeat (4) applyStimulus(16'd200, 16'd200, 1'b1, 1'b1, 3'd0, 4'h7);
    @(posedge clk);
    #3;
    rst = 1'b1;
    i_de = 1'b0;
    #1;
    checkAllZero("midreset");
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'd200, 16'd200, 1'b1, 1'b0, 3'd0, 4'h0);
    applyStimulus(16'hFFF0, 16'd0,  1'b1, 1'b0, 3'd0, 4'h0);
    applyStimulus(16'd201, 16'd200, 1'b1, 1'b0, 3'd0, 4'h0);
    idle();

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("sb_drain", 32'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
